// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, grant codes, default read latency.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_ISSUE = 3'b001,
    ST_WAIT  = 3'b010,
    ST_RESP  = 3'b011
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } grant_t;

  localparam int LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and single-port memory signals; slave is the arbiter's view, master the environment's.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection; with MEM_ARB_RR_EN a tie goes to whoever was not served last,
// otherwise data always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  logic   last_d,
`endif
  output grant_t pick
);

  always_comb begin
    pick = GNT_NONE;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      pick = last_d ? GNT_I : GNT_D;
`else
      pick = GNT_D;
`endif
    end else if (d_req) begin
      pick = GNT_D;
    end else if (i_req) begin
      pick = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: ack LAT+2 cycles after grant, one transaction per LAT+3.
// Requesters hold until ack; MEM_ARB_RR_EN selects round-robin tie-break instead of data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic [1:0]    grant_out,
  output logic [2:0]    state_out
);

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t        state;
  grant_t        grant;
  grant_t        pick;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  mem_arb_pick u_pick (
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .last_d (last_d),
    .pick   (pick)
  );

  // Last-served starts as fetch so the first tie is handed to data.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      last_d <= 1'b0;
    end else if (state == ST_IDLE && pick != GNT_NONE) begin
      last_d <= (pick == GNT_D);
    end
  end
`else
  mem_arb_pick u_pick (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .pick  (pick)
  );
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      grant     <= GNT_NONE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick != GNT_NONE) begin
            grant    <= pick;
            state    <= ST_ISSUE;
            mem_en_q <= 1'b1;
            if (pick == GNT_D) begin
              lat_addr  <= bus.d_addr;
              lat_we    <= bus.d_we;
              lat_wdata <= bus.d_wdata;
              mem_we_q  <= bus.d_we;
            end else begin
              lat_addr <= bus.i_addr;
              lat_we   <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
            // Read data is only valid on the final wait cycle; writes leave rdata untouched.
            if (!lat_we) begin
              if (grant == GNT_D) d_rdata_q <= bus.mem_rdata;
              else                i_rdata_q <= bus.mem_rdata;
            end
            if (grant == GNT_D) d_ack_q <= 1'b1;
            else                i_ack_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          grant <= GNT_NONE;
          state <= ST_IDLE;
        end
        default: begin
          grant <= GNT_NONE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  assign busy      = (state != ST_IDLE);
  assign grant_out = grant;
  assign state_out = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT 2, 1, 15), latency-pipelined memory models, ack scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(32), .DW(32)) bus0 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus15 ();

  logic       busy0, busy1, busy15;
  logic [1:0] grant0, grant1, grant15;
  logic [2:0] state0, state1, state15;

  mem_arbiter #(.AW(32), .DW(32), .LAT(2)) u_dut (
    .clk(clk), .Reset(Reset), .bus(bus0),
    .busy(busy0), .grant_out(grant0), .state_out(state0)
  );
  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_dut1 (
    .clk(clk), .Reset(Reset), .bus(bus1),
    .busy(busy1), .grant_out(grant1), .state_out(state1)
  );
  mem_arbiter #(.AW(32), .DW(32), .LAT(15)) u_dut15 (
    .clk(clk), .Reset(Reset), .bus(bus15),
    .busy(busy15), .grant_out(grant15), .state_out(state15)
  );

  localparam int LATS [3] = '{2, 1, 15};

  logic        iack [3];
  logic        dack [3];
  logic [31:0] irdata [3];
  logic [31:0] drdata [3];
  logic        men [3];
  logic        mwe [3];
  logic [31:0] maddr [3];
  logic [31:0] mrd [3];

  assign iack[0] = bus0.i_ack;      assign iack[1] = bus1.i_ack;      assign iack[2] = bus15.i_ack;
  assign dack[0] = bus0.d_ack;      assign dack[1] = bus1.d_ack;      assign dack[2] = bus15.d_ack;
  assign irdata[0] = bus0.i_rdata;  assign irdata[1] = bus1.i_rdata;  assign irdata[2] = bus15.i_rdata;
  assign drdata[0] = bus0.d_rdata;  assign drdata[1] = bus1.d_rdata;  assign drdata[2] = bus15.d_rdata;
  assign men[0] = bus0.mem_en;      assign men[1] = bus1.mem_en;      assign men[2] = bus15.mem_en;
  assign mwe[0] = bus0.mem_we;      assign mwe[1] = bus1.mem_we;      assign mwe[2] = bus15.mem_we;
  assign maddr[0] = bus0.mem_addr;  assign maddr[1] = bus1.mem_addr;  assign maddr[2] = bus15.mem_addr;
  assign bus0.mem_rdata = mrd[0];
  assign bus1.mem_rdata = mrd[1];
  assign bus15.mem_rdata = mrd[2];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234 : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory model: read data appears exactly LAT cycles after the mem_en cycle, garbage otherwise.
  logic [15:0] vp [3];
  logic [31:0] ap [3][16];
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      vp[u]    <= {vp[u][14:0], men[u] & ~mwe[u]};
      ap[u][0] <= maddr[u];
      for (int k = 1; k < 16; k++) ap[u][k] <= ap[u][k-1];
    end
  end
  always_comb begin
    for (int u = 0; u < 3; u++) begin
      mrd[u] = 32'hDEAD_BEEF;
      if (vp[u][LATS[u]-1] === 1'b1) mrd[u] = mem_f(ap[u][LATS[u]-1]);
    end
  end

  typedef struct {
    int          unit;
    int          cyc;
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int t;
  int r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  always @(negedge clk) begin
    if (men[0] === 1'b1) chk("mem_en_in_issue", 64'(state0), 64'(ST_ISSUE));
    for (int u = 0; u < 3; u++) begin
      if (iack[u] === 1'b1 || dack[u] === 1'b1) begin
        chk("ack_exclusive", 64'(iack[u] & dack[u]), 64'd0);
        chk("ack_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("ack_unit", 64'(u), 64'(mon_e.unit));
          chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("ack_src_is_d", 64'(dack[u]), 64'(mon_e.is_d));
          chk("ack_rdata", 64'(mon_e.is_d ? drdata[u] : irdata[u]), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    bus0.i_req = 0;  bus0.i_addr = 0;  bus0.d_req = 0;  bus0.d_we = 0;  bus0.d_addr = 0;  bus0.d_wdata = 0;
    bus1.i_req = 0;  bus1.i_addr = 0;  bus1.d_req = 0;  bus1.d_we = 0;  bus1.d_addr = 0;  bus1.d_wdata = 0;
    bus15.i_req = 0; bus15.i_addr = 0; bus15.d_req = 0; bus15.d_we = 0; bus15.d_addr = 0; bus15.d_wdata = 0;

    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_grant", 64'(grant0), 64'd0);
    chk("rst_mem_en", 64'(bus0.mem_en), 64'd0);
    chk("rst_acks", 64'({bus0.i_ack, bus0.d_ack}), 64'd0);
    chk("rst_rdata", 64'({bus0.i_rdata, bus0.d_rdata}), 64'd0);
    repeat (17) @(posedge clk);
    #1 Reset = 1'b0;

    // Single fetch; request dropped after grant still completes.
    go();
    bus0.i_req = 1; bus0.i_addr = 32'h10;
    sb.push_back('{unit: 0, cyc: t + 4, is_d: 1'b0, data: 32'h1234});
    at_neg(t);
    chk("f_idle_busy", 64'(busy0), 64'd0);
    at_neg(t + 1);
    chk("f_mem_en", 64'(bus0.mem_en), 64'd1);
    chk("f_mem_addr", 64'(bus0.mem_addr), 64'h10);
    chk("f_mem_we", 64'(bus0.mem_we), 64'd0);
    chk("f_busy_t1", 64'(busy0), 64'd1);
    chk("f_grant", 64'(grant0), 64'(GNT_I));
    bus0.i_req = 0;
    at_neg(t + 2);
    chk("f_wait_state", 64'(state0), 64'(ST_WAIT));
    chk("f_mem_en_once", 64'(bus0.mem_en), 64'd0);
    at_neg(t + 4);
    chk("f_resp_state", 64'(state0), 64'(ST_RESP));
    chk("f_busy_t4", 64'(busy0), 64'd1);
    at_neg(t + 5);
    chk("f_idle_after", 64'({busy0, grant0}), 64'd0);
    chk("f_rdata_hold", 64'(bus0.i_rdata), 64'h1234);

    // Simultaneous requests.
    go();
    bus0.i_req = 1; bus0.i_addr = 32'h44;
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h40;
    sb.push_back('{unit: 0, cyc: t + 4, is_d: 1'b1, data: mem_f(32'h40)});
    sb.push_back('{unit: 0, cyc: t + 9, is_d: 1'b0, data: mem_f(32'h44)});
`ifdef MEM_ARB_RR_EN
    sb.push_back('{unit: 0, cyc: t + 14, is_d: 1'b1, data: mem_f(32'h40)});
`endif
    at_neg(t + 1);
    chk("tie_first_grant", 64'(grant0), 64'(GNT_D));
    chk("tie_first_addr", 64'(bus0.mem_addr), 64'h40);
`ifndef MEM_ARB_RR_EN
    at_neg(t + 4);
    bus0.d_req = 0;
`endif
    at_neg(t + 6);
    chk("tie_second_en", 64'(bus0.mem_en), 64'd1);
    chk("tie_second_addr", 64'(bus0.mem_addr), 64'h44);
    chk("tie_second_grant", 64'(grant0), 64'(GNT_I));
`ifdef MEM_ARB_RR_EN
    at_neg(t + 11);
    chk("rr_third_grant", 64'(grant0), 64'(GNT_D));
    chk("rr_third_en", 64'(bus0.mem_en), 64'd1);
    at_neg(t + 14);
    bus0.i_req = 0; bus0.d_req = 0;
`else
    at_neg(t + 9);
    bus0.i_req = 0;
`endif
    at_neg(t + 16);

    // Data write leaves both rdata registers alone.
    go();
    bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h20; bus0.d_wdata = 32'hCAFE;
    sb.push_back('{unit: 0, cyc: t + 4, is_d: 1'b1, data: mem_f(32'h40)});
    at_neg(t + 1);
    chk("w_mem_we", 64'(bus0.mem_we), 64'd1);
    chk("w_mem_addr", 64'(bus0.mem_addr), 64'h20);
    chk("w_mem_wdata", 64'(bus0.mem_wdata), 64'hCAFE);
    at_neg(t + 2);
    chk("w_mem_we_once", 64'({bus0.mem_en, bus0.mem_we}), 64'd0);
    at_neg(t + 4);
    bus0.d_req = 0; bus0.d_we = 0;
    at_neg(t + 5);
    chk("w_d_rdata_kept", 64'(bus0.d_rdata), 64'(mem_f(32'h40)));
    chk("w_i_rdata_kept", 64'(bus0.i_rdata), 64'(mem_f(32'h44)));

    // Reset in WAIT aborts; held fetch re-arbitrates after release.
    go();
    bus0.i_req = 1; bus0.i_addr = 32'h80;
    at_neg(t + 1);
    @(posedge clk);
    #1 Reset = 1'b1;
    #1;
    chk("ra_state", 64'(state0), 64'd0);
    chk("ra_busy_grant", 64'({busy0, grant0}), 64'd0);
    chk("ra_mem", 64'({bus0.mem_en, bus0.mem_we, bus0.mem_addr}), 64'd0);
    chk("ra_rdata", 64'({bus0.i_rdata, bus0.d_rdata}), 64'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    r = cyc;
    sb.push_back('{unit: 0, cyc: r + 4, is_d: 1'b0, data: mem_f(32'h80)});
    at_neg(r + 1);
    chk("ra_reissue_addr", 64'(bus0.mem_addr), 64'h80);
    bus0.i_req = 0;
    at_neg(r + 6);

    // Latency extremes.
    go();
    bus1.i_req = 1; bus1.i_addr = 32'h10;
    sb.push_back('{unit: 1, cyc: t + 3, is_d: 1'b0, data: 32'h1234});
    at_neg(t + 1);
    bus1.i_req = 0;
    at_neg(t + 5);
    go();
    bus15.i_req = 1; bus15.i_addr = 32'h30;
    sb.push_back('{unit: 2, cyc: t + 17, is_d: 1'b0, data: mem_f(32'h30)});
    at_neg(t + 1);
    bus15.i_req = 0;

    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
